// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, states,
// write-back selects and the opcode classes latched in DECODE.
package riscv_multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC4    = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_JUMP,
    CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_FENCE
  } op_class_e;

  typedef enum logic [1:0] {
    DEC_OK, DEC_SYSTEM, DEC_ILLEGAL
  } dec_kind_e;

  typedef struct packed {
    dec_kind_e kind;
    op_class_e cls;
  } dec_t;

  function automatic dec_t decode_opcode(input logic [6:0] opc);
    dec_t d;
    d.kind = DEC_OK;
    d.cls  = CLS_ALU;
    case (opc)
      OPC_LUI:      d.cls = CLS_LUI;
      OPC_AUIPC:    d.cls = CLS_AUIPC;
      OPC_JAL,
      OPC_JALR:     d.cls = CLS_JUMP;
      OPC_BRANCH:   d.cls = CLS_BRANCH;
      OPC_LOAD:     d.cls = CLS_LOAD;
      OPC_STORE:    d.cls = CLS_STORE;
      OPC_OP_IMM,
      OPC_OP:       d.cls = CLS_ALU;
      OPC_MISC_MEM: d.cls = CLS_FENCE;
      OPC_SYSTEM:   d.kind = DEC_SYSTEM;
      default:      d.kind = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/riscv_ctrl_timeout.sv
// Bus wait counter: cleared when a request starts, counts cycles without ack,
// flags expiry in the MEM_TIMEOUT-th waiting cycle. Saturates once expired.
module riscv_ctrl_timeout #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] cnt_reg;

  assign o_expire = (cnt_reg == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_reg <= '0;
    end else if (i_clear) begin
      cnt_reg <= '0;
    end else if (i_inc && !o_expire) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences register enables, write-back/PC
// selects and memory handshakes; counts retirements and halts on faults.
module riscv_multicycle_ctrl
  import riscv_multicycle_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [6:0]      i_opcode,
  input  logic            i_branch_taken,
  input  logic            i_imem_ack,
  input  logic            i_dmem_ack,
  output logic            o_imem_req,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic            o_pc_en,
  output logic            o_ir_en,
  output logic            o_ab_en,
  output logic            o_aluout_en,
  output logic            o_mdr_en,
  output logic            o_rf_we,
  output logic            o_pc_sel,
  output logic [1:0]      o_wb_sel,
  output logic [2:0]      o_state,
  output logic [XLEN-1:0] o_instret,
  output logic            o_illegal,
  output logic            o_bus_err
);

  state_e          state_reg, state_next;
  op_class_e       class_reg, class_next;
  logic [XLEN-1:0] instret_reg;
  logic            illegal_reg, bus_err_reg;
  logic            retire, set_illegal, set_bus_err;
  logic            to_clear, to_inc, to_expire;
  wb_sel_e         wb_sel;
  dec_t            dec;

  assign dec = decode_opcode(i_opcode);

  always_comb begin
    state_next  = state_reg;
    class_next  = class_reg;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    o_imem_req  = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_pc_en     = 1'b0;
    o_ir_en     = 1'b0;
    o_ab_en     = 1'b0;
    o_aluout_en = 1'b0;
    o_mdr_en    = 1'b0;
    o_rf_we     = 1'b0;
    o_pc_sel    = 1'b0;
    wb_sel      = WB_ALUOUT;
    case (state_reg)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        o_imem_req = 1'b1;
        // An ack in the expiry cycle still completes the fetch.
        if (i_imem_ack) begin
          o_ir_en    = 1'b1;
          state_next = ST_DECODE;
        end else if (to_expire) begin
          set_bus_err = 1'b1;
          state_next  = ST_HALT;
        end
      end
      ST_DECODE: begin
        o_ab_en    = 1'b1;
        class_next = dec.cls;
        case (dec.kind)
          DEC_OK:     state_next = ST_EXEC;
          DEC_SYSTEM: state_next = ST_HALT;
          default: begin
            set_illegal = 1'b1;
            state_next  = ST_HALT;
          end
        endcase
      end
      ST_EXEC: begin
        o_aluout_en = 1'b1;
        case (class_reg)
          CLS_BRANCH: begin
            o_pc_en    = 1'b1;
            o_pc_sel   = i_branch_taken;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          default:             state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (class_reg == CLS_STORE);
        if (i_dmem_ack) begin
          if (class_reg == CLS_STORE) begin
            o_pc_en    = 1'b1;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            o_mdr_en   = 1'b1;
            state_next = ST_WB;
          end
        end else if (to_expire) begin
          set_bus_err = 1'b1;
          state_next  = ST_HALT;
        end
      end
      ST_WB: begin
        o_pc_en    = 1'b1;
        retire     = 1'b1;
        state_next = ST_FETCH;
        o_rf_we    = (class_reg != CLS_FENCE);
        o_pc_sel   = (class_reg == CLS_JUMP);
        if (class_reg == CLS_LOAD)      wb_sel = WB_MDR;
        else if (class_reg == CLS_JUMP) wb_sel = WB_PC4;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // Counter restarts whenever a new request phase begins.
  assign to_clear = (state_next != state_reg) &&
                    ((state_next == ST_FETCH) || (state_next == ST_MEM));
  assign to_inc   = ((state_reg == ST_FETCH) && !i_imem_ack) ||
                    ((state_reg == ST_MEM) && !i_dmem_ack);

  riscv_ctrl_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clear  (to_clear),
    .i_inc    (to_inc),
    .o_expire (to_expire)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg   <= ST_IDLE;
      class_reg   <= CLS_ALU;
      instret_reg <= '0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      class_reg <= class_next;
      if (retire)      instret_reg <= instret_reg + XLEN'(1);
      if (set_illegal) illegal_reg <= 1'b1;
      if (set_bus_err) bus_err_reg <= 1'b1;
    end
  end

  assign o_state   = state_reg;
  assign o_wb_sel  = wb_sel;
  assign o_instret = instret_reg;
  assign o_illegal = illegal_reg;
  assign o_bus_err = bus_err_reg;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle output vectors,
// a monitor pops and compares them at each falling clock edge.
module tb_riscv_multicycle_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic [9:0]  ctl;   // {imem,dmem,we,pc,ir,ab,alu,mdr,rf,pc_sel}
    logic [1:0]  wsel;
    logic [31:0] ret;
    logic        ill;
    logic        berr;
  } obs_t;

  localparam logic [9:0] C_0      = 10'b0000000000;
  localparam logic [9:0] C_FW     = 10'b1000000000;
  localparam logic [9:0] C_FA     = 10'b1000100000;
  localparam logic [9:0] C_DEC    = 10'b0000010000;
  localparam logic [9:0] C_EX     = 10'b0000001000;
  localparam logic [9:0] C_WB     = 10'b0001000010;
  localparam logic [9:0] C_WB_NRF = 10'b0001000000;
  localparam logic [9:0] C_WB_JMP = 10'b0001000011;
  localparam logic [9:0] C_BR_T   = 10'b0001001001;
  localparam logic [9:0] C_BR_N   = 10'b0001001000;
  localparam logic [9:0] C_LDW    = 10'b0100000000;
  localparam logic [9:0] C_LDA    = 10'b0100000100;
  localparam logic [9:0] C_STW    = 10'b0110000000;
  localparam logic [9:0] C_STA    = 10'b0111000000;

  localparam logic [6:0] ADDI = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, FENCE = 7'b0001111;
  localparam logic [6:0] ECALL = 7'b1110011, BAD = 7'b1111111;

  logic        clk, rstn;
  logic [6:0]  opcode;
  logic        br, iack, dack;
  logic        imem_req, dmem_req, dmem_we, pc_en, ir_en, ab_en, aluout_en, mdr_en;
  logic        rf_we, pc_sel, illegal, bus_err;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;
  obs_t        obs;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passed = 0;

  riscv_multicycle_ctrl #(.XLEN(32), .MEM_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_opcode(opcode), .i_branch_taken(br),
    .i_imem_ack(iack), .i_dmem_ack(dack),
    .o_imem_req(imem_req), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_pc_en(pc_en), .o_ir_en(ir_en), .o_ab_en(ab_en), .o_aluout_en(aluout_en),
    .o_mdr_en(mdr_en), .o_rf_we(rf_we), .o_pc_sel(pc_sel), .o_wb_sel(wb_sel),
    .o_state(state), .o_instret(instret), .o_illegal(illegal), .o_bus_err(bus_err)
  );

  assign obs = '{st: state,
                 ctl: {imem_req, dmem_req, dmem_we, pc_en, ir_en, ab_en, aluout_en,
                       mdr_en, rf_we, pc_sel},
                 wsel: wb_sel, ret: instret, ill: illegal, berr: bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t ex(input logic [2:0] st, input logic [9:0] ctl,
                              input logic [1:0] ws, input logic [31:0] ret,
                              input logic ill, input logic be);
    obs_t o;
    o.st = st; o.ctl = ctl; o.wsel = ws; o.ret = ret; o.ill = ill; o.berr = be;
    return o;
  endfunction

  task automatic cyc(input logic rst, input logic [6:0] op, input logic b,
                     input logic ia, input logic da, input obs_t e, input string t);
    @(posedge clk);
    #1;
    rstn = rst; opcode = op; br = b; iack = ia; dack = da;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_reset();
    cyc(1'b0, ADDI, 1'b0, 1'b1, 1'b1, ex(3'd0, C_0, 2'd0, 0, 0, 0), "rst");
    cyc(1'b1, ADDI, 1'b0, 1'b1, 1'b1, ex(3'd0, C_0, 2'd0, 0, 0, 0), "idle");
  endtask

  // Register-writing instruction that skips MEM: FETCH, DECODE, EXEC, WB.
  task automatic alu_like(input logic [6:0] op, input logic [9:0] wbc,
                          input logic [1:0] ws, input logic [31:0] r, input string t);
    cyc(1'b1, op, 1'b0, 1'b1, 1'b1, ex(3'd1, C_FA, 2'd0, r, 0, 0), {t, "_fetch"});
    cyc(1'b1, op, 1'b0, 1'b1, 1'b1, ex(3'd2, C_DEC, 2'd0, r, 0, 0), {t, "_decode"});
    cyc(1'b1, op, 1'b0, 1'b1, 1'b1, ex(3'd3, C_EX, 2'd0, r, 0, 0), {t, "_exec"});
    cyc(1'b1, op, 1'b0, 1'b1, 1'b1, ex(3'd5, wbc, ws, r, 0, 0), {t, "_wb"});
    $display("txn %s retire_count_before=%0d", t, r);
  endtask

  task automatic branch(input logic tk, input logic [31:0] r, input string t);
    cyc(1'b1, BEQ, tk, 1'b1, 1'b1, ex(3'd1, C_FA, 2'd0, r, 0, 0), {t, "_fetch"});
    cyc(1'b1, BEQ, tk, 1'b1, 1'b1, ex(3'd2, C_DEC, 2'd0, r, 0, 0), {t, "_decode"});
    cyc(1'b1, BEQ, tk, 1'b1, 1'b1, ex(3'd3, tk ? C_BR_T : C_BR_N, 2'd0, r, 0, 0),
        {t, "_exec"});
    $display("txn %s retire_count_before=%0d", t, r);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL %s: got st=%0d ctl=%b ws=%0d ret=%0d ill=%b berr=%b required st=%0d ctl=%b ws=%0d ret=%0d ill=%b berr=%b",
                 t, obs.st, obs.ctl, obs.wsel, obs.ret, obs.ill, obs.berr,
                 e.st, e.ctl, e.wsel, e.ret, e.ill, e.berr);
      else
        passed++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; opcode = ADDI; br = 1'b0; iack = 1'b1; dack = 1'b1;
    cyc(1'b0, ADDI, 1'b0, 1'b1, 1'b1, ex(3'd0, C_0, 2'd0, 0, 0, 0), "rst0");
    do_reset();

    alu_like(ADDI, C_WB, 2'd0, 0, "addi");

    // LW with data ack withheld for three cycles.
    cyc(1'b1, LW, 1'b0, 1'b1, 1'b0, ex(3'd1, C_FA, 2'd0, 1, 0, 0), "lw_fetch");
    cyc(1'b1, LW, 1'b0, 1'b1, 1'b0, ex(3'd2, C_DEC, 2'd0, 1, 0, 0), "lw_decode");
    cyc(1'b1, LW, 1'b0, 1'b1, 1'b0, ex(3'd3, C_EX, 2'd0, 1, 0, 0), "lw_exec");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, LW, 1'b0, 1'b1, 1'b0, ex(3'd4, C_LDW, 2'd0, 1, 0, 0), "lw_mem_wait");
    cyc(1'b1, LW, 1'b0, 1'b1, 1'b1, ex(3'd4, C_LDA, 2'd0, 1, 0, 0), "lw_mem_ack");
    cyc(1'b1, LW, 1'b0, 1'b1, 1'b1, ex(3'd5, C_WB, 2'd1, 1, 0, 0), "lw_wb");
    $display("txn lw retire_count_before=1");

    branch(1'b1, 2, "beq_taken");
    branch(1'b0, 3, "beq_not_taken");
    alu_like(JAL, C_WB_JMP, 2'd2, 4, "jal");

    cyc(1'b1, SW, 1'b0, 1'b1, 1'b1, ex(3'd1, C_FA, 2'd0, 5, 0, 0), "sw_fetch");
    cyc(1'b1, SW, 1'b0, 1'b1, 1'b1, ex(3'd2, C_DEC, 2'd0, 5, 0, 0), "sw_decode");
    cyc(1'b1, SW, 1'b0, 1'b1, 1'b1, ex(3'd3, C_EX, 2'd0, 5, 0, 0), "sw_exec");
    cyc(1'b1, SW, 1'b0, 1'b1, 1'b1, ex(3'd4, C_STA, 2'd0, 5, 0, 0), "sw_mem_ack");
    $display("txn sw retire_count_before=5");

    alu_like(FENCE, C_WB_NRF, 2'd0, 6, "fence");

    // SW interrupted by an asynchronous reset while waiting in MEM.
    cyc(1'b1, SW, 1'b0, 1'b1, 1'b0, ex(3'd1, C_FA, 2'd0, 7, 0, 0), "swr_fetch");
    cyc(1'b1, SW, 1'b0, 1'b1, 1'b0, ex(3'd2, C_DEC, 2'd0, 7, 0, 0), "swr_decode");
    cyc(1'b1, SW, 1'b0, 1'b1, 1'b0, ex(3'd3, C_EX, 2'd0, 7, 0, 0), "swr_exec");
    cyc(1'b1, SW, 1'b0, 1'b1, 1'b0, ex(3'd4, C_STW, 2'd0, 7, 0, 0), "swr_mem_wait");
    @(posedge clk);
    #1;
    exp_q.push_back(ex(3'd0, C_0, 2'd0, 0, 0, 0));
    tag_q.push_back("swr_async_reset");
    #2 rstn = 1'b0;
    $display("txn sw_reset_mid_mem");
    do_reset();

    // Retire one ADDI, then an illegal opcode freezes everything.
    alu_like(ADDI, C_WB, 2'd0, 0, "addi2");
    cyc(1'b1, BAD, 1'b0, 1'b1, 1'b1, ex(3'd1, C_FA, 2'd0, 1, 0, 0), "ill_fetch");
    cyc(1'b1, BAD, 1'b0, 1'b1, 1'b1, ex(3'd2, C_DEC, 2'd0, 1, 0, 0), "ill_decode");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, ADDI, 1'b1, 1'b1, 1'b1, ex(3'd6, C_0, 2'd0, 1, 1, 0), "ill_halt");
    $display("txn illegal_opcode");

    do_reset();
    cyc(1'b1, ECALL, 1'b0, 1'b1, 1'b1, ex(3'd1, C_FA, 2'd0, 0, 0, 0), "ecall_fetch");
    cyc(1'b1, ECALL, 1'b0, 1'b1, 1'b1, ex(3'd2, C_DEC, 2'd0, 0, 0, 0), "ecall_decode");
    cyc(1'b1, ECALL, 1'b0, 1'b1, 1'b1, ex(3'd6, C_0, 2'd0, 0, 0, 0), "ecall_halt");
    $display("txn ecall");

    // Fetch ack withheld for the full window: bus error; stray dmem ack ignored.
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc(1'b1, ADDI, 1'b0, 1'b0, 1'b1, ex(3'd1, C_FW, 2'd0, 0, 0, 0), "to_fetch_wait");
    cyc(1'b1, ADDI, 1'b0, 1'b0, 1'b1, ex(3'd6, C_0, 2'd0, 0, 0, 1), "to_halt");
    cyc(1'b1, ADDI, 1'b0, 1'b1, 1'b1, ex(3'd6, C_0, 2'd0, 0, 0, 1), "to_halt_hold");
    $display("txn fetch_timeout");

    // Ack arriving in the final waiting cycle still completes the fetch.
    do_reset();
    for (int i = 0; i < 15; i++)
      cyc(1'b1, ADDI, 1'b0, 1'b0, 1'b0, ex(3'd1, C_FW, 2'd0, 0, 0, 0), "late_fetch_wait");
    cyc(1'b1, ADDI, 1'b0, 1'b1, 1'b0, ex(3'd1, C_FA, 2'd0, 0, 0, 0), "late_fetch_ack");
    cyc(1'b1, ADDI, 1'b0, 1'b1, 1'b0, ex(3'd2, C_DEC, 2'd0, 0, 0, 0), "late_decode");
    $display("txn late_ack_wins");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
